attitude_classifier: RTL



---
 rtl/attitude_pkg.sv | 30 +++
 rtl/attitude_classifier_if.sv | 23 ++
 rtl/axis_hysteresis.sv | 54 +++++
 rtl/attitude_classifier.sv | 94 +++++++++
 4 files changed

// File: rtl/attitude_pkg.sv
// Shared attitude-code definitions used by the classifier and the downstream
// seven-segment decoder.
package attitude_pkg;

  localparam int unsigned ATT_W          = 4;
  localparam int unsigned ATT_SGN_ROLL   = 0;
  localparam int unsigned ATT_SGN_PITCH  = 1;
  localparam int unsigned ATT_ZERO_ROLL  = 2;
  localparam int unsigned ATT_ZERO_PITCH = 3;

  typedef logic [ATT_W-1:0] att_code_t;

  // Level attitude: both axes near zero, signs cleared.
  localparam att_code_t ATT_LEVEL = 4'b1100;

  // Assemble an attitude code from the per-axis sign/zero flags.
  function automatic att_code_t att_pack(input logic sgn_roll,
                                         input logic sgn_pitch,
                                         input logic zero_roll,
                                         input logic zero_pitch);
    att_code_t code;
    code                 = '0;
    code[ATT_SGN_ROLL]   = sgn_roll;
    code[ATT_SGN_PITCH]  = sgn_pitch;
    code[ATT_ZERO_ROLL]  = zero_roll;
    code[ATT_ZERO_PITCH] = zero_pitch;
    return code;
  endfunction

endpackage

// File: rtl/attitude_classifier_if.sv
// Sample/result bus between the IMU angle path and the attitude classifier.
import attitude_pkg::*;

interface attitude_classifier_if #(
  parameter int ANGLE_W = 16
);
  logic                      i_Valid;
  logic signed [ANGLE_W-1:0] i_Roll;
  logic signed [ANGLE_W-1:0] i_Pitch;
  logic                      i_Sync_Clr;
  att_code_t                 o_Attitude;
  logic                      o_Update;

  modport master (
    output i_Valid, i_Roll, i_Pitch, i_Sync_Clr,
    input  o_Attitude, o_Update
  );

  modport slave (
    input  i_Valid, i_Roll, i_Pitch, i_Sync_Clr,
    output o_Attitude, o_Update
  );
endinterface

// File: rtl/axis_hysteresis.sv
// Per-axis near-zero classifier: saturating magnitude, hysteresis on the
// zero flag, and the sign/zero pair the new sample would produce.
module axis_hysteresis #(
  parameter int ANGLE_W    = 16,
  parameter int ZERO_ENTER = 64,
  parameter int ZERO_EXIT  = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [ANGLE_W-1:0] sample,
  input  logic                      valid,
  input  logic                      clear,
  output logic                      zero_next,
  output logic                      sgn_next
);

  localparam logic [ANGLE_W-1:0] MOST_NEG = {1'b1, {(ANGLE_W-1){1'b0}}};
  localparam logic [ANGLE_W-1:0] MAG_MAX  = {1'b0, {(ANGLE_W-1){1'b1}}};
  localparam logic [ANGLE_W-1:0] ENTER_L  = ANGLE_W'(ZERO_ENTER);
  localparam logic [ANGLE_W-1:0] EXIT_L   = ANGLE_W'(ZERO_EXIT);

  logic [ANGLE_W-1:0] raw;
  logic [ANGLE_W-1:0] mag;
  logic               zero_q;

  assign raw = sample;

  // Absolute value; the most negative input has no positive twin and saturates.
  always_comb begin
    mag = raw;
    if (raw[ANGLE_W-1]) begin
      if (raw == MOST_NEG) mag = MAG_MAX;
      else                 mag = ~raw + ANGLE_W'(1);
    end
  end

  // Hysteresis: leave zero only above EXIT, enter zero only at or below ENTER.
  always_comb begin
    zero_next = zero_q;
    if (valid) begin
      if (zero_q) zero_next = !(mag > EXIT_L);
      else        zero_next = (mag <= ENTER_L);
    end
    sgn_next = zero_next ? 1'b0 : raw[ANGLE_W-1];
  end

  // Zero-flag register; clear wins over a coincident valid sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      zero_q <= 1'b1;
    else if (clear)  zero_q <= 1'b1;
    else if (valid)  zero_q <= zero_next;
  end

endmodule

// File: rtl/attitude_classifier.sv
// Classifies roll/pitch into a 4-bit attitude code, debounces it over
// STABLE_COUNT identical samples and presents a registered code plus strobe.
import attitude_pkg::*;

module attitude_classifier #(
  parameter int ANGLE_W      = 16,
  parameter int ZERO_ENTER   = 64,
  parameter int ZERO_EXIT    = 128,
  parameter int STABLE_COUNT = 4
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  attitude_classifier_if.slave bus
);

  localparam int unsigned       CNT_W    = $clog2(STABLE_COUNT + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(STABLE_COUNT);

  logic       zero_roll, sgn_roll;
  logic       zero_pitch, sgn_pitch;
  att_code_t  cand_new;
  att_code_t  cand_q;
  logic [CNT_W-1:0] count_q;
  att_code_t  att_q;
  logic       upd_q;

  axis_hysteresis #(
    .ANGLE_W   (ANGLE_W),
    .ZERO_ENTER(ZERO_ENTER),
    .ZERO_EXIT (ZERO_EXIT)
  ) u_roll (
    .clk      (i_Clk),
    .rst_n    (i_Rst_n),
    .sample   (bus.i_Roll),
    .valid    (bus.i_Valid),
    .clear    (bus.i_Sync_Clr),
    .zero_next(zero_roll),
    .sgn_next (sgn_roll)
  );

  axis_hysteresis #(
    .ANGLE_W   (ANGLE_W),
    .ZERO_ENTER(ZERO_ENTER),
    .ZERO_EXIT (ZERO_EXIT)
  ) u_pitch (
    .clk      (i_Clk),
    .rst_n    (i_Rst_n),
    .sample   (bus.i_Pitch),
    .valid    (bus.i_Valid),
    .clear    (bus.i_Sync_Clr),
    .zero_next(zero_pitch),
    .sgn_next (sgn_pitch)
  );

  assign cand_new = att_pack(sgn_roll, sgn_pitch, zero_roll, zero_pitch);

  // Stage 1: register the candidate and track how long it has been steady.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cand_q  <= ATT_LEVEL;
      count_q <= '0;
    end else if (bus.i_Sync_Clr) begin
      cand_q  <= ATT_LEVEL;
      count_q <= '0;
    end else if (bus.i_Valid) begin
      if (cand_new == cand_q) begin
        if (count_q != CNT_FULL) count_q <= count_q + CNT_W'(1);
      end else begin
        count_q <= CNT_W'(1);
      end
      cand_q <= cand_new;
    end
  end

  // Stage 2: publish a stable candidate only when it differs from the display.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      att_q <= ATT_LEVEL;
      upd_q <= 1'b0;
    end else if (bus.i_Sync_Clr) begin
      att_q <= ATT_LEVEL;
      upd_q <= 1'b0;
    end else if ((count_q == CNT_FULL) && (cand_q != att_q)) begin
      att_q <= cand_q;
      upd_q <= 1'b1;
    end else begin
      upd_q <= 1'b0;
    end
  end

  assign bus.o_Attitude = att_q;
  assign bus.o_Update   = upd_q;

endmodule
